// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: q = a - b, LSB first, one bit per clock.
// A single full-subtractor cell and a borrow flop stand in for a WIDTH-bit ripple
// chain. Operands are accepted under a start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             borrow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Terminal count is detected by equality, so the counter never needs to wrap.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {StIdle, StRun} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] q_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] q_nxt;

  // Full-subtractor cell on the current LSBs, plus the result register shifted by one.
  always_comb begin
    d      = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    q_nxt  = {d, q_sh[WIDTH-1:1]};
  end

  // Handshake FSM and serial datapath; outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= StIdle;
      busy   <= 1'b0;
      done   <= 1'b0;
      q      <= '0;
      borrow <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      q_sh   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end
        end
        StRun: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          q_sh <= q_nxt;
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Publish the fully assembled result in the same edge as the last bit.
            q      <= q_nxt;
            borrow <= br_nxt;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed WIDTH=4 scenarios and a
// randomized WIDTH=8 sweep checked against plain-arithmetic expectations.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, borrow4;
  logic [3:0] q4;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, borrow8;
  logic [7:0] q8;

  int compared;
  int mismatched;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .q(q4), .borrow(borrow4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .q(q8), .borrow(borrow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    step(); step();
    rst = 1'b0;
    step();
    compared++;
    if ({busy4, done4, q4, borrow4} !== 7'b0) begin
      mismatched++;
      $display("FAIL reset4: busy=%b done=%b q=%h borrow=%b required all 0",
               busy4, done4, q4, borrow4);
    end
    compared++;
    if ({busy8, done8, q8, borrow8} !== 11'b0) begin
      mismatched++;
      $display("FAIL reset8: busy=%b done=%b q=%h borrow=%b required all 0",
               busy8, done8, q8, borrow8);
    end
    for (int i = 0; i < 5; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom);
      step();
      compared++;
      if ({busy4, done4, q4, borrow4} !== 7'b0) begin
        mismatched++;
        $display("FAIL idle_nostart: busy=%b done=%b q=%h borrow=%b required all 0",
                 busy4, done4, q4, borrow4);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] ta [4];
    logic [3:0] tb [4];
    logic [3:0] exp_q;
    logic       exp_b;
    ta = '{4'd9, 4'd3, 4'd0, 4'd7};
    tb = '{4'd3, 4'd9, 4'd15, 4'd7};
    for (int v = 0; v < 4; v++) begin
      exp_q = 4'((int'(ta[v]) - int'(tb[v])) & 15);
      exp_b = (ta[v] < tb[v]);
      start4 = 1'b1; a4 = ta[v]; b4 = tb[v];
      step();                       // edge n: accepted
      start4 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        a4 = 4'($urandom); b4 = 4'($urandom);
        step();
        compared++;
        if (done4 !== (k == 4)) begin
          mismatched++;
          $display("FAIL basic_done v%0d edge n+%0d: done=%b required %b",
                   v, k, done4, (k == 4));
        end
        if (k < 4) begin
          compared++;
          if (busy4 !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_busy v%0d edge n+%0d: busy=%b required 1", v, k, busy4);
          end
        end
      end
      compared++;
      if (q4 !== exp_q || borrow4 !== exp_b || busy4 !== 1'b0) begin
        mismatched++;
        $display("FAIL basic_result %0d-%0d: q=%h borrow=%b busy=%b required q=%h borrow=%b busy=0",
                 ta[v], tb[v], q4, borrow4, busy4, exp_q, exp_b);
      end
      step();                       // done must drop after one cycle
      compared++;
      if (done4 !== 1'b0 || q4 !== exp_q || borrow4 !== exp_b) begin
        mismatched++;
        $display("FAIL basic_hold v%0d: done=%b q=%h borrow=%b required done=0 q=%h borrow=%b",
                 v, done4, q4, borrow4, exp_q, exp_b);
      end
    end
  endtask

  task automatic test_back_to_back();
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    step();                         // edge n
    for (int k = 1; k <= 4; k++) begin
      // Re-requests at edges n+1..n+3 must be ignored.
      start4 = (k <= 3);
      a4 = 4'($urandom); b4 = 4'($urandom);
      step();
    end
    compared++;
    if (done4 !== 1'b1 || q4 !== 4'h6 || borrow4 !== 1'b0) begin
      mismatched++;
      $display("FAIL ignore_start: done=%b q=%h borrow=%b required done=1 q=6 borrow=0",
               done4, q4, borrow4);
    end
    // Restart in the done cycle.
    start4 = 1'b1; a4 = 4'd15; b4 = 4'd1;
    step();
    start4 = 1'b0;
    compared++;
    if (done4 !== 1'b0 || busy4 !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_accept: done=%b busy=%b required done=0 busy=1", done4, busy4);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      compared++;
      if (done4 !== (k == 4)) begin
        mismatched++;
        $display("FAIL b2b_done edge +%0d: done=%b required %b", k, done4, (k == 4));
      end
    end
    compared++;
    if (q4 !== 4'hE || borrow4 !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_result: q=%h borrow=%b required q=e borrow=0", q4, borrow4);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd2;
    step();                         // edge n
    start4 = 1'b0;
    step();                         // edge n+1
    rst = 1'b1;
    step();                         // edge n+2 with reset
    rst = 1'b0;
    compared++;
    if ({busy4, done4, q4, borrow4} !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_mid: busy=%b done=%b q=%h borrow=%b required all 0",
               busy4, done4, q4, borrow4);
    end
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done4 === 1'b1) seen_done++;
    end
    compared++;
    if (seen_done != 0 || q4 !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_mid_quiet: done pulses=%0d q=%h required 0 pulses q=0",
               seen_done, q4);
    end
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
    step();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    compared++;
    if (done4 !== 1'b1 || q4 !== 4'h7 || borrow4 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_recover: done=%b q=%h borrow=%b required done=1 q=7 borrow=0",
               done4, q4, borrow4);
    end
  endtask

  task automatic test_sweep8();
    logic [7:0] av, bv, exp_q;
    logic       exp_b;
    int         lat;
    for (int op = 0; op < 1000; op++) begin
      av = 8'($urandom); bv = 8'($urandom);
      if (op == 0) begin av = 8'd0; bv = 8'd255; end
      if (op == 1) begin av = 8'd77; bv = 8'd77; end
      exp_q = av - bv;
      exp_b = (av < bv);
      start8 = 1'b1; a8 = av; b8 = bv;
      step();                       // acceptance edge
      start8 = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12 && lat == 0; k++) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        step();
        if (done8 === 1'b1) lat = k;
      end
      compared++;
      if (lat != 8) begin
        mismatched++;
        $display("FAIL sweep_latency op%0d: done after %0d edges required 8", op, lat);
      end
      compared++;
      if (q8 !== exp_q || borrow8 !== exp_b) begin
        mismatched++;
        $display("FAIL sweep_result op%0d %0d-%0d: q=%h borrow=%b required q=%h borrow=%b",
                 op, av, bv, q8, borrow8, exp_q, exp_b);
      end
      // Mix back-to-back restarts with short idle gaps.
      for (int g = $urandom_range(2, 0); g > 0; g--) step();
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_sweep8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
